// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if -- signal bundle between a PS/2 keyboard front end and
// its consumer.
//   master : drives ps2_clk, ps2_data and rx_en; observes the receiver results
//   slave  : the receiver itself; returns key_code, tecla_lista, rx_busy and
//            frame_err
interface ps2_keyboard_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rx_en;
   logic [7:0] key_code;
   logic       tecla_lista;
   logic       rx_busy;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data, rx_en,
      input  key_code, tecla_lista, rx_busy, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data, rx_en,
      output key_code, tecla_lista, rx_busy, frame_err
   );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx -- PS/2 keyboard receiver returning make codes.
//   clk, reset  : system clock and synchronous active-high reset
//   bus (slave) : ps2_clk/ps2_data keyboard lines (asynchronous), rx_en,
//                 key_code (last accepted make code), tecla_lista (one-cycle
//                 new-code strobe), rx_busy (frame in progress), frame_err
//                 (one-cycle parity/stop/timeout error strobe)
// Break sequences (F0 xx) and the E0 extended prefix are consumed silently.
module ps2_keyboard_rx #(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input logic              clk,
   input logic              reset,
   ps2_keyboard_rx_if.slave bus
);

   localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // synchronizers
   logic [1:0] clk_sync;
   logic [1:0] data_sync;
   logic       clk_s;
   logic       data_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[0], bus.ps2_clk};
         data_sync <= {data_sync[0], bus.ps2_data};
      end
   end

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];

   // clock deglitch: the filtered level flips only after FILTER_LEN
   // consecutive samples that disagree with it; any agreeing sample restarts
   // the run.
   logic [FW-1:0] filt_cnt;
   logic          filt_clk;
   logic          filt_clk_d;
   logic          fall;

   always_ff @(posedge clk) begin
      if (reset) begin
         filt_cnt   <= '0;
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
      end else begin
         filt_clk_d <= filt_clk;
         if (clk_s == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_MAX) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall = filt_clk_d & ~filt_clk;

   // frame FSM
   state_t        state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par_bit, par_bit_n;
   logic [TW-1:0] to_cnt, to_cnt_n;
   logic          brk, brk_n;
   logic [7:0]    key_q, key_n;
   logic          tecla_q, tecla_n;
   logic          err_q, err_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         to_cnt  <= '0;
         brk     <= 1'b0;
         key_q   <= '0;
         tecla_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         shreg   <= shreg_n;
         par_bit <= par_bit_n;
         to_cnt  <= to_cnt_n;
         brk     <= brk_n;
         key_q   <= key_n;
         tecla_q <= tecla_n;
         err_q   <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_bit_n = par_bit;
      to_cnt_n  = to_cnt;
      brk_n     = brk;
      key_n     = key_q;
      tecla_n   = 1'b0;
      err_n     = 1'b0;

      if (!bus.rx_en) begin
         state_n  = IDLE;
         to_cnt_n = '0;
      end else begin
         to_cnt_n = (state == IDLE || fall) ? '0 : to_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (fall && !data_s) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end
            end
            DATA: begin
               if (fall) begin
                  shreg_n   = {data_s, shreg[7:1]};
                  bit_cnt_n = bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state_n = PARITY;
               end
            end
            PARITY: begin
               if (fall) begin
                  par_bit_n = data_s;
                  state_n   = STOP;
               end
            end
            STOP: begin
               if (fall) begin
                  state_n = IDLE;
                  if (data_s && (^{shreg, par_bit})) begin
                     if (shreg == 8'hF0) begin
                        brk_n = 1'b1;
                     end else if (shreg == 8'hE0) begin
                        brk_n = brk;
                     end else if (brk) begin
                        brk_n = 1'b0;
                     end else begin
                        key_n   = shreg;
                        tecla_n = 1'b1;
                     end
                  end else begin
                     err_n = 1'b1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
         // an edge arriving in the timeout cycle wins; the abort only
         // applies when no fall was processed above
         if (!fall && state != IDLE && to_cnt == TO_MAX) begin
            state_n  = IDLE;
            to_cnt_n = '0;
            err_n    = 1'b1;
         end
      end
   end

   assign bus.key_code    = key_q;
   assign bus.tecla_lista = tecla_q;
   assign bus.rx_busy     = (state != IDLE);
   assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx -- self-checking bench for ps2_keyboard_rx. Drives PS/2
// frames on the interface and compares strobe counts, key_code and error
// counts against a byte-level model of the make/break/extended rules.
module tb_ps2_keyboard_rx;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 600;
   localparam int HALF        = 20;

   logic clk = 1'b0;
   logic reset;

   ps2_keyboard_rx_if bus ();

   ps2_keyboard_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // monitor
   int cyc = 0;
   int pulse_cnt = 0;
   int err_cnt = 0;
   int consec = 0;
   int last_pulse_cyc = 0;
   logic prev_t = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.tecla_lista) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
            if (prev_t) consec++;
         end
         if (bus.frame_err) err_cnt++;
      end
      prev_t = bus.tecla_lista;
   end

   // reference model
   logic [7:0] key_exp = 8'h00;
   int         pulse_exp = 0;
   int         err_exp = 0;
   bit         brk_exp = 1'b0;
   bit         pulse_now = 1'b0;
   int         stop_cyc = 0;

   task automatic model(input logic [7:0] b, input bit good);
      pulse_now = 1'b0;
      if (!good) err_exp++;
      else if (b == 8'hF0) brk_exp = 1'b1;
      else if (b == 8'hE0) begin end
      else if (brk_exp) brk_exp = 1'b0;
      else begin
         key_exp   = b;
         pulse_exp++;
         pulse_now = 1'b1;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, output int fall_cyc);
      tick(1);
      bus.ps2_data = b;
      tick(HALF);
      bus.ps2_clk = 1'b0;
      fall_cyc = cyc;
      tick(HALF);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int gap);
      logic [10:0] f;
      int fc;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         send_bit(f[i], fc);
         if (i == 10) stop_cyc = fc;
      end
      bus.ps2_data = 1'b1;
      tick(gap);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      int fc;
      send_bit(1'b0, fc);
      for (int i = 0; i < nbits; i++) send_bit(b[i], fc);
      bus.ps2_data = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick(4);
      n_checks++;
      if (bus.key_code !== 8'h00) begin n_fail++; $display("FAIL reset_key: got %h expected 00", bus.key_code); end
      n_checks++;
      if (bus.tecla_lista !== 1'b0) begin n_fail++; $display("FAIL reset_tecla: got %b expected 0", bus.tecla_lista); end
      n_checks++;
      if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.rx_busy); end
      n_checks++;
      if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.frame_err); end
      reset = 1'b0;
      tick(4);
   endtask

   task automatic test_single_make;
      model(8'h1C, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b0, 30);
      n_checks++;
      if (bus.key_code !== key_exp) begin n_fail++; $display("FAIL single_key: got %h expected %h", bus.key_code, key_exp); end
      n_checks++;
      if (pulse_cnt !== pulse_exp) begin n_fail++; $display("FAIL single_pulses: got %0d expected %0d", pulse_cnt, pulse_exp); end
      n_checks++;
      if (err_cnt !== err_exp) begin n_fail++; $display("FAIL single_err: got %0d expected %0d", err_cnt, err_exp); end
      n_checks++;
      if (last_pulse_cyc - stop_cyc < FILTER_LEN + 2 || last_pulse_cyc - stop_cyc > FILTER_LEN + 4) begin
         n_fail++; $display("FAIL single_latency: got %0d cycles expected %0d..%0d", last_pulse_cyc - stop_cyc, FILTER_LEN + 2, FILTER_LEN + 4);
      end
   endtask

   task automatic test_break_sequence;
      logic [7:0] seq [5] = '{8'h16, 8'hF0, 8'h16, 8'hE0, 8'h75};
      int p0;
      p0 = pulse_cnt;
      for (int i = 0; i < 5; i++) begin
         model(seq[i], 1'b1);
         send_frame(seq[i], 1'b0, 1'b0, 30);
         if (i == 2) begin
            n_checks++;
            if (pulse_cnt - p0 !== 1 || bus.key_code !== 8'h16) begin
               n_fail++; $display("FAIL break_first: got %0d pulses key %h expected 1 pulses key 16", pulse_cnt - p0, bus.key_code);
            end
         end
      end
      n_checks++;
      if (pulse_cnt !== pulse_exp) begin n_fail++; $display("FAIL break_pulses: got %0d expected %0d", pulse_cnt, pulse_exp); end
      n_checks++;
      if (bus.key_code !== 8'h75) begin n_fail++; $display("FAIL break_key: got %h expected 75", bus.key_code); end
      n_checks++;
      if (err_cnt !== err_exp) begin n_fail++; $display("FAIL break_err: got %0d expected %0d", err_cnt, err_exp); end
   endtask

   task automatic test_parity_error;
      model(8'h45, 1'b0);
      send_frame(8'h45, 1'b1, 1'b0, 30);
      n_checks++;
      if (err_cnt !== err_exp) begin n_fail++; $display("FAIL parity_err: got %0d expected %0d", err_cnt, err_exp); end
      n_checks++;
      if (pulse_cnt !== pulse_exp) begin n_fail++; $display("FAIL parity_pulses: got %0d expected %0d", pulse_cnt, pulse_exp); end
      n_checks++;
      if (bus.key_code !== key_exp) begin n_fail++; $display("FAIL parity_key: got %h expected %h", bus.key_code, key_exp); end
   endtask

   task automatic test_timeout;
      send_partial(8'h5A, 4);
      tick(5);
      n_checks++;
      if (bus.rx_busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_mid: got %b expected 1", bus.rx_busy); end
      err_exp++;
      tick(TIMEOUT_CYC + 40);
      n_checks++;
      if (err_cnt !== err_exp) begin n_fail++; $display("FAIL timeout_err: got %0d expected %0d", err_cnt, err_exp); end
      n_checks++;
      if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_end: got %b expected 0", bus.rx_busy); end
      model(8'h29, 1'b1);
      send_frame(8'h29, 1'b0, 1'b0, 30);
      n_checks++;
      if (bus.key_code !== key_exp || pulse_cnt !== pulse_exp || err_cnt !== err_exp) begin
         n_fail++; $display("FAIL timeout_recover: got key %h pulses %0d errs %0d expected key %h pulses %0d errs %0d",
                             bus.key_code, pulse_cnt, err_cnt, key_exp, pulse_exp, err_exp);
      end
   endtask

   task automatic test_idle_edges;
      int busy_seen;
      int fc;
      busy_seen = 0;
      for (int g = 0; g < 3; g++) begin
         bus.ps2_data = 1'b0;
         bus.ps2_clk  = 1'b0;
         tick(FILTER_LEN - 1);
         bus.ps2_clk  = 1'b1;
         for (int k = 0; k < 20; k++) begin
            tick(1);
            if (bus.rx_busy) busy_seen++;
         end
      end
      bus.ps2_data = 1'b1;
      n_checks++;
      if (busy_seen !== 0) begin n_fail++; $display("FAIL glitch_busy: got %0d busy cycles expected 0", busy_seen); end
      // a genuine falling edge with data high is not a start bit
      send_bit(1'b1, fc);
      tick(30);
      n_checks++;
      if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_high_edge: got %b expected 0", bus.rx_busy); end
      n_checks++;
      if (err_cnt !== err_exp) begin n_fail++; $display("FAIL idle_err: got %0d expected %0d", err_cnt, err_exp); end
   endtask

   task automatic test_rx_en;
      model(8'hF0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b0, 30);
      send_partial(8'h33, 3);
      tick(3);
      bus.rx_en = 1'b0;
      tick(3);
      n_checks++;
      if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL rxen_busy: got %b expected 0", bus.rx_busy); end
      tick(20);
      bus.rx_en = 1'b1;
      tick(5);
      n_checks++;
      if (err_cnt !== err_exp) begin n_fail++; $display("FAIL rxen_err: got %0d expected %0d", err_cnt, err_exp); end
      model(8'h33, 1'b1);
      send_frame(8'h33, 1'b0, 1'b0, 30);
      model(8'h33, 1'b1);
      send_frame(8'h33, 1'b0, 1'b0, 30);
      n_checks++;
      if (pulse_cnt !== pulse_exp || bus.key_code !== key_exp) begin
         n_fail++; $display("FAIL rxen_break_kept: got pulses %0d key %h expected pulses %0d key %h",
                             pulse_cnt, bus.key_code, pulse_exp, key_exp);
      end
   endtask

   task automatic test_reset_midframe;
      send_partial(8'h1E, 5);
      tick(2);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      key_exp = 8'h00;
      brk_exp = 1'b0;
      tick(10);
      n_checks++;
      if (bus.key_code !== 8'h00 || bus.rx_busy !== 1'b0) begin
         n_fail++; $display("FAIL midreset_state: got key %h busy %b expected key 00 busy 0", bus.key_code, bus.rx_busy);
      end
      model(8'h1E, 1'b1);
      send_frame(8'h1E, 1'b0, 1'b0, 30);
      n_checks++;
      if (bus.key_code !== 8'h1E) begin n_fail++; $display("FAIL midreset_key: got %h expected 1e", bus.key_code); end
      n_checks++;
      if (pulse_cnt !== pulse_exp || err_cnt !== err_exp) begin
         n_fail++; $display("FAIL midreset_counts: got pulses %0d errs %0d expected pulses %0d errs %0d",
                             pulse_cnt, err_cnt, pulse_exp, err_exp);
      end
   endtask

   task automatic test_random;
      logic [7:0] b;
      int sel;
      int e;
      for (int n = 0; n < 24; n++) begin
         sel = $urandom_range(0, 7);
         b = (sel == 0) ? 8'hF0 : (sel == 1) ? 8'hE0 : 8'($urandom);
         e = $urandom_range(0, 9);
         model(b, e > 1);
         send_frame(b, e == 0, e == 1, 30);
         n_checks++;
         if (pulse_cnt !== pulse_exp || err_cnt !== err_exp || bus.key_code !== key_exp) begin
            n_fail++; $display("FAIL random_frame_%0d: byte %h got pulses %0d errs %0d key %h expected pulses %0d errs %0d key %h",
                                n, b, pulse_cnt, err_cnt, bus.key_code, pulse_exp, err_exp, key_exp);
         end
         if (pulse_now) begin
            n_checks++;
            if (last_pulse_cyc - stop_cyc < FILTER_LEN + 2 || last_pulse_cyc - stop_cyc > FILTER_LEN + 4) begin
               n_fail++; $display("FAIL random_latency_%0d: got %0d cycles expected %0d..%0d", n, last_pulse_cyc - stop_cyc, FILTER_LEN + 2, FILTER_LEN + 4);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] b;
      for (int n = 0; n < 6; n++) begin
         b = 8'($urandom_range(1, 8'h7F));
         model(b, 1'b1);
         send_frame(b, 1'b0, 1'b0, (n == 5) ? 30 : 0);
      end
      n_checks++;
      if (pulse_cnt !== pulse_exp || err_cnt !== err_exp || bus.key_code !== key_exp) begin
         n_fail++; $display("FAIL b2b: got pulses %0d errs %0d key %h expected pulses %0d errs %0d key %h",
                             pulse_cnt, err_cnt, bus.key_code, pulse_exp, err_exp, key_exp);
      end
      n_checks++;
      if (consec !== 0) begin n_fail++; $display("FAIL tecla_consecutive: got %0d expected 0", consec); end
   endtask

   initial begin
      reset        = 1'b1;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      bus.rx_en    = 1'b1;
      tick(3);
      test_reset();
      test_single_make();
      test_break_sequence();
      test_parity_error();
      test_timeout();
      test_idle_edges();
      test_rx_en();
      test_reset_midframe();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples required before the filtered ps2_clk changes.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: clk cycles without a filtered falling edge that abort a frame in progress.
REQ-003 SHALL have port clk, input, 1: system clock, single clock domain.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1: asynchronous keyboard clock line.
REQ-006 SHALL have port ps2_data, input, 1: asynchronous keyboard data line.
REQ-007 SHALL have port rx_en, input, 1: receive enable; low forces IDLE.
REQ-008 SHALL have port key_code, output, 8: last accepted make-code byte, in raw scan-code form.
REQ-009 SHALL have port tecla_lista, output, 1: one-cycle strobe indicating that a new key_code is valid.
REQ-010 SHALL have port rx_busy, output, 1: high while the FSM is not in IDLE.
REQ-011 SHALL have port frame_err, output, 1: one-cycle strobe on a parity, stop-bit or timeout error.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers before any use.
REQ-013 SHALL update the filtered clock only after FILTER_LEN consecutive identical synchronized samples; reset value of the filtered clock 1.
REQ-014 SHALL generate a one-cycle fall strobe when the filtered clock transitions 1->0; ps2_data SHALL be sampled (synchronized value) in that cycle.
REQ-015 SHALL implement the states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on fall with data=0 -> DATA with bit count 0; on fall with data=1 the edge SHALL be ignored and the FSM SHALL remain in IDLE.
REQ-017 DATA: on each fall, SHALL shift data in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: on fall, SHALL store the parity bit -> STOP.
REQ-019 STOP: on fall, the frame is good if stop=1 and the 8 data bits plus parity have odd parity; in either case -> IDLE.
REQ-020 A bad frame SHALL pulse frame_err for one cycle, SHALL discard the byte, and SHALL leave key_code and the break flag unchanged.
REQ-021 Timeout counter SHALL clear on every fall and in IDLE; when it reaches TIMEOUT_CYC outside IDLE -> IDLE, frame_err SHALL pulse for one cycle, and the byte SHALL be discarded.
REQ-022 Good byte 0xF0: SHALL set the break flag with no strobe.
REQ-023 Good byte 0xE0: SHALL be discarded with no strobe and no flag change.
REQ-024 Any other good byte with break flag=1: SHALL clear the flag and discard the byte, with no strobe.
REQ-025 Any other good byte with break flag=0: SHALL load key_code and pulse tecla_lista high for exactly one cycle; both actions SHALL occur in the cycle after the stop-bit fall.
REQ-026 key_code SHALL hold its value until the next accepted make code; tecla_lista SHALL never be high for two consecutive cycles.
REQ-027 rx_en=0: FSM SHALL be held in IDLE, any partial frame SHALL be discarded without frame_err, and the break flag SHALL be preserved.
REQ-028 If timeout and fall occur in the same cycle, fall SHALL take priority.

Reset
REQ-029 reset=1 SHALL force, on the next clk edge: FSM IDLE, key_code 0x00, tecla_lista 0, rx_busy 0, frame_err 0, break flag 0, counters 0, filtered clock 1, synchronizers 1.
REQ-030 A reset asserted mid-frame SHALL abort the frame with no strobe and no frame_err.

Verification
REQ-031 Frame for 0x1C (start 0, bits LSB first, parity 0, stop 1), FILTER_LEN=8 -> key_code=0x1C, one tecla_lista pulse, frame_err never high.
REQ-032 Sequence 0x16, 0xF0, 0x16 -> exactly one tecla_lista pulse, key_code=0x16; then 0xE0, 0x75 -> one pulse, key_code=0x75.
REQ-033 Frame 0x45 with parity inverted -> frame_err pulses once, no tecla_lista pulse, key_code keeps its prior value.
REQ-034 Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYC cycles -> frame_err pulses once, rx_busy returns to 0; a following good 0x29 frame is received correctly.
REQ-035 Glitches on ps2_clk of FILTER_LEN-1 cycles during IDLE -> no state change, rx_busy stays 0.
REQ-036 reset pulse after the 5th data bit, then a full 0x1E frame -> key_code=0x1E, one pulse, no frame_err.
